// File: rtl/ddr_wr_arb.sv
// Two-port AXI write arbiter in front of a single DDR write port.
// Define WLAST_CHK_EN to drive m_axi_wlast from the beat counter and flag source WLAST mismatches.
module ddr_wr_arb #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [7:0]              s0_axi_awlen,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wlast,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [7:0]              s1_axi_awlen,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wlast,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [1:0]              grant,
    output logic                    wlast_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                state_q, state_d;
    logic                  own_q, own_d;
    logic                  prio_q, prio_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  pick;
    logic                  own_wvalid;
    logic                  own_wlast;
    logic                  beat;
    logic                  last_beat;
    logic                  in_data;
    logic                  unused_bid;
`ifdef WLAST_CHK_EN
    logic                  err_q, err_d;
    logic                  exp_last;
`endif

    assign unused_bid = ^m_axi_bid;

    always_comb begin
        state_d        = state_q;
        own_d          = own_q;
        prio_d         = prio_q;
        addr_d         = addr_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        s0_axi_awready = 1'b0;
        s1_axi_awready = 1'b0;
        in_data        = (state_q == DATA);
        // prio_q names the port that wins a tie
        pick       = s1_axi_awvalid & (~s0_axi_awvalid | prio_q);
        own_wvalid = own_q ? s1_axi_wvalid : s0_axi_wvalid;
        own_wlast  = own_q ? s1_axi_wlast : s0_axi_wlast;
        beat       = in_data & own_wvalid & m_axi_wready;
`ifdef WLAST_CHK_EN
        err_d       = err_q;
        exp_last    = (cnt_q == len_q);
        last_beat   = beat & exp_last;
        m_axi_wlast = in_data & exp_last;
        wlast_err   = err_q;
`else
        last_beat   = beat & own_wlast;
        m_axi_wlast = in_data & own_wlast;
        wlast_err   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (s0_axi_awvalid | s1_axi_awvalid) begin
                    s0_axi_awready = ~pick & rst_n;
                    s1_axi_awready = pick & rst_n;
                    own_d   = pick;
                    prio_d  = ~pick;
                    addr_d  = pick ? s1_axi_awaddr : s0_axi_awaddr;
                    len_d   = pick ? s1_axi_awlen : s0_axi_awlen;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_awready) begin
                    cnt_d   = 8'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
`ifdef WLAST_CHK_EN
                    if (own_wlast != exp_last) err_d = 1'b1;
`endif
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        m_axi_awid    = ID_WIDTH'(own_q);
        m_axi_awaddr  = addr_q;
        m_axi_awlen   = len_q;
        m_axi_awsize  = 3'd6;
        m_axi_awburst = 2'b01;
        m_axi_awvalid = (state_q == ADDR);
        m_axi_wvalid  = in_data & own_wvalid;
        m_axi_wdata   = own_q ? s1_axi_wdata : s0_axi_wdata;
        m_axi_wstrb   = own_q ? s1_axi_wstrb : s0_axi_wstrb;
        s0_axi_wready = in_data & ~own_q & m_axi_wready;
        s1_axi_wready = in_data & own_q & m_axi_wready;
        grant         = (state_q == IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);

        // write responses are steered by ID alone, decoupled from the W burst
        s0_axi_bvalid = m_axi_bvalid & ~m_axi_bid[0];
        s1_axi_bvalid = m_axi_bvalid & m_axi_bid[0];
        s0_axi_bresp  = m_axi_bresp;
        s1_axi_bresp  = m_axi_bresp;
        m_axi_bready  = m_axi_bid[0] ? s1_axi_bready : s0_axi_bready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
`ifdef WLAST_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef WLAST_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
